conv_window_sched: RTL and testbench

- Frame-level sequencer for the K×K dot-product convolution engine.
- Walks every valid output position of an IMG_W×IMG_H single-channel image (stride 1, no padding).
- For each position it does four things in order:
  - reads K*K pixels from the image RAM;
  - packs them into the engine's X vector;
  - drives the engine's level-sensitive start until done;
  - writes the engine result to the feature-map RAM.
- Sits between the image buffer, one conv engine instance and the layer output buffer.

---
 rtl/conv_sched_pkg.sv | 29 ++
 rtl/conv_win_addr_gen.sv | 81 ++++++++
 rtl/conv_window_sched.sv | 144 ++++++++++++++
 tb/tb_conv_window_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
`default_nettype none
// ============================================================================
// conv_sched_pkg : shared state type and sizing helpers for conv_window_sched
// Revision: 1.0
// ============================================================================
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DRAIN   = 3'd2,
    COMPUTE = 3'd3,
    WRITE   = 3'd4
  } sched_state_t;

  function automatic int unsigned out_dim(input int unsigned img_dim, input int unsigned k);
    return img_dim - k + 1;
  endfunction

  function automatic int unsigned win_n(input int unsigned k);
    return k * k;
  endfunction

  function automatic int unsigned elem_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_win_addr_gen.sv
`default_nettype none
// ============================================================================
// conv_win_addr_gen : output-position and window-tap counters with image/output
// RAM address generation. Optional macro: CONV_SCHED_WINDOW_REUSE_EN
// Revision: 1.0
// ============================================================================
module conv_win_addr_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 5,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              tap_step,
  input  logic              win_step,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       tap_idx,
  output logic              last_tap,
  output logic              last_col,
  output logic              last_window
);
  import conv_sched_pkg::*;

  localparam int unsigned OUT_W    = out_dim(IMG_W, K);
  localparam int unsigned OUT_H    = out_dim(IMG_H, K);
  localparam int unsigned LAST_COL = OUT_W - 1;
  localparam int unsigned LAST_ROW = OUT_H - 1;
  localparam int unsigned LAST_TAP = K - 1;

  logic [31:0] row, col, r, c;
  // Set while fetching only the newly exposed column of a reused window.
  logic        narrow;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row    <= '0;
      col    <= '0;
      r      <= '0;
      c      <= '0;
      narrow <= 1'b0;
    end else if (win_step) begin
      r <= '0;
      if (col == LAST_COL) begin
        col    <= '0;
        row    <= (row == LAST_ROW) ? '0 : row + 1;
        c      <= '0;
        narrow <= 1'b0;
      end else begin
        col <= col + 1;
`ifdef CONV_SCHED_WINDOW_REUSE_EN
        c      <= LAST_TAP;
        narrow <= 1'b1;
`else
        c      <= '0;
        narrow <= 1'b0;
`endif
      end
    end else if (tap_step) begin
      if (narrow) begin
        r <= r + 1;
      end else if (c == LAST_TAP) begin
        c <= '0;
        r <= r + 1;
      end else begin
        c <= c + 1;
      end
    end
  end

  assign pix_addr    = ADDR_W'((row + r) * IMG_W + col + c);
  assign out_addr    = ADDR_W'(row * OUT_W + col);
  assign tap_idx     = r * K + c;
  assign last_tap    = (r == LAST_TAP) && (c == LAST_TAP);
  assign last_col    = (col == LAST_COL);
  assign last_window = (row == LAST_ROW) && (col == LAST_COL);

endmodule
`default_nettype wire

// File: rtl/conv_window_sched.sv
`default_nettype none
// ============================================================================
// conv_window_sched : frame sequencer feeding K*K windows to the conv engine.
// Optional macro: CONV_SCHED_WINDOW_REUSE_EN (column-shift window reuse)
// Revision: 1.0
// ============================================================================
module conv_window_sched #(
  parameter int INWIDTH  = 8,
  parameter int OUTWIDTH = 25,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int K        = 5,
  parameter int ADDR_W   = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     pix_rd_en,
  output logic [ADDR_W-1:0]        pix_addr,
  input  logic [INWIDTH-1:0]       pix_data,
  output logic                     eng_start,
  output logic [K*K*INWIDTH-1:0]   eng_x,
  input  logic                     eng_done,
  input  logic [OUTWIDTH-1:0]      eng_result,
  output logic                     out_wr_en,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [OUTWIDTH-1:0]      out_data
);
  import conv_sched_pkg::*;

  localparam int unsigned WIN_N = win_n(K);
  localparam int unsigned XW    = WIN_N * INWIDTH;
  localparam int unsigned XIW   = (XW > 1) ? $clog2(XW) : 1;

  sched_state_t state, state_nxt;
  logic         clear, tap_step, win_step;
  logic         last_tap, last_col, last_window;
  logic [31:0]  tap_idx, cap_idx;
  logic         cap_valid;
  logic [XIW-1:0] cap_lsb;

  conv_win_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .tap_step   (tap_step),
    .win_step   (win_step),
    .pix_addr   (pix_addr),
    .out_addr   (out_addr),
    .tap_idx    (tap_idx),
    .last_tap   (last_tap),
    .last_col   (last_col),
    .last_window(last_window)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    clear      = 1'b0;
    tap_step   = 1'b0;
    win_step   = 1'b0;
    pix_rd_en  = 1'b0;
    eng_start  = 1'b0;
    out_wr_en  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          clear     = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        pix_rd_en = 1'b1;
        if (last_tap) state_nxt = DRAIN;
        else          tap_step  = 1'b1;
      end
      DRAIN: state_nxt = COMPUTE;
      COMPUTE: begin
        eng_start = 1'b1;
        if (eng_done) state_nxt = WRITE;
      end
      WRITE: begin
        out_wr_en = 1'b1;
        win_step  = 1'b1;
        if (last_window) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  // Read data returns one cycle after the strobe, so the tap index is delayed to match.
  assign cap_lsb = XIW'(elem_lsb(cap_idx, INWIDTH));

`ifdef CONV_SCHED_WINDOW_REUSE_EN
  logic [XW-1:0] x_shift;
  for (genvar gi = 0; gi < WIN_N; gi++) begin : g_shift
    if ((gi % K) != (K - 1)) begin : g_take
      assign x_shift[gi*INWIDTH +: INWIDTH] = eng_x[(gi+1)*INWIDTH +: INWIDTH];
    end else begin : g_keep
      assign x_shift[gi*INWIDTH +: INWIDTH] = eng_x[gi*INWIDTH +: INWIDTH];
    end
  end
`else
  logic unused_last_col;
  assign unused_last_col = last_col;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      eng_x     <= '0;
      out_data  <= '0;
      cap_valid <= 1'b0;
      cap_idx   <= '0;
    end else begin
      cap_valid <= (state == FETCH);
      cap_idx   <= tap_idx;
      if (cap_valid) eng_x[cap_lsb +: INWIDTH] <= pix_data;
      if ((state == COMPUTE) && eng_done) out_data <= eng_result;
`ifdef CONV_SCHED_WINDOW_REUSE_EN
      if ((state == WRITE) && !last_col) eng_x <= x_shift;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_conv_window_sched : directed self-checking bench for conv_window_sched
// Revision: 1.0
// ============================================================================
module tb_conv_window_sched;
  localparam int INWIDTH  = 8;
  localparam int OUTWIDTH = 25;
  localparam int IMG_W    = 6;
  localparam int IMG_H    = 6;
  localparam int K        = 3;
  localparam int ADDR_W   = 10;
  localparam int WIN_N    = K * K;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   go = 1'b0;
  logic                   busy, frame_done, pix_rd_en, eng_start, eng_done, out_wr_en;
  logic [ADDR_W-1:0]      pix_addr, out_addr;
  logic [INWIDTH-1:0]     pix_data = '0;
  logic [WIN_N*INWIDTH-1:0] eng_x;
  logic [OUTWIDTH-1:0]    eng_result, out_data;

  conv_window_sched #(
    .INWIDTH(INWIDTH), .OUTWIDTH(OUTWIDTH), .IMG_W(IMG_W),
    .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy), .frame_done(frame_done),
    .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_data(pix_data),
    .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done),
    .eng_result(eng_result), .out_wr_en(out_wr_en), .out_addr(out_addr),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Image RAM: pixel value equals its address, one-cycle read latency.
  always @(posedge clk) if (pix_rd_en) pix_data <= INWIDTH'(pix_addr);

  // Engine model: sums the window, done eng_delay cycles after start rises.
  int eng_delay = 4;
  int eng_cnt = 0;
  int eng_sum;
  always @(posedge clk) eng_cnt <= eng_start ? eng_cnt + 1 : 0;
  assign eng_done = eng_start && (eng_cnt == eng_delay);
  always_comb begin
    eng_sum = 0;
    for (int i = 0; i < WIN_N; i++) eng_sum += int'(eng_x[i*INWIDTH +: INWIDTH]);
  end
  assign eng_result = OUTWIDTH'(eng_sum);

  int checks = 0;
  int failures = 0;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor of writes, reads and engine-start gaps.
  int wr_a[$], wr_d[$], rd_a[$], rd_c[$];
  int lo_run = 0, min_gap = 1000;
  bit seen_hi = 1'b0;
  always @(negedge clk) begin
    if (out_wr_en) begin
      wr_a.push_back(int'(out_addr));
      wr_d.push_back(int'(out_data));
    end
    if (pix_rd_en) begin
      rd_a.push_back(int'(pix_addr));
      rd_c.push_back(cyc);
    end
    if (eng_start) begin
      if (seen_hi && lo_run > 0 && lo_run < min_gap) min_gap = lo_run;
      lo_run  = 0;
      seen_hi = 1'b1;
    end else begin
      lo_run++;
    end
  end

  // Window at (row,col) of a pixel=address image: 63 + 9*(6*row+col).
  function automatic int exp_val(input int a);
    return 63 + 9 * (IMG_W * (a / 4) + (a % 4));
  endfunction

  task automatic wait_frame_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_start(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (eng_start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic verify_frame(input int wb, input string tag);
    check($sformatf("%s_nwr", tag), wr_a.size() - wb, 16);
    for (int i = 0; i < 16 && wb + i < wr_a.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_a[wb+i], i);
      check($sformatf("%s_data%0d", tag, i), wr_d[wb+i], exp_val(i));
    end
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  initial begin
    bit ok;
    int wb, rb, held, bad;
    logic [WIN_N*INWIDTH-1:0] snap_x;
    logic [OUTWIDTH-1:0]      snap_d;
    int exp_rd0[9]  = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
`ifdef CONV_SCHED_WINDOW_REUSE_EN
    int exp_rd1[3]  = '{3, 9, 15};
    int exp_nrd     = 4 * 9 + 12 * 3;
`else
    int exp_rd1[9]  = '{1, 2, 3, 7, 8, 9, 13, 14, 15};
    int exp_nrd     = 16 * 9;
`endif

    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, frame_done, pix_rd_en, eng_start, out_wr_en}, 0);
    check("rst_addrs", {pix_addr, out_addr}, 0);
    check("rst_eng_x", eng_x, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // Frame 1: nominal run, read order, ignored go pulses.
    wb = wr_a.size();
    rb = rd_a.size();
    go = 1'b1;
    @(negedge clk);
    check("busy_after_go", busy, 1);
    go = 1'b0;
    wait_start(200, ok);
    check("f1_start_seen", ok, 1);
    check("f1_elem4", eng_x[4*INWIDTH +: INWIDTH], 7);
    pulse_go();
    wait_frame_done(2000, ok);
    check("f1_done_seen", ok, 1);
    check("f1_done_wr_en", out_wr_en, 1);
    check("f1_done_addr", out_addr, 15);
    check("f1_done_data", out_data, 252);
    pulse_go();
    check("busy_drop", busy, 0);
    repeat (5) @(negedge clk);
    check("no_restart_busy", busy, 0);
    verify_frame(wb, "f1");
    check("f1_nrd", rd_a.size() - rb, exp_nrd);
    for (int i = 0; i < 9 && rb + i < rd_a.size(); i++)
      check($sformatf("rd0_%0d", i), rd_a[rb+i], exp_rd0[i]);
    if (rb + 8 < rd_a.size()) check("rd0_consecutive", rd_c[rb+8] - rd_c[rb], 8);
    for (int i = 0; i < $size(exp_rd1) && rb + 9 + i < rd_a.size(); i++)
      check($sformatf("rd1_%0d", i), rd_a[rb+9+i], exp_rd1[i]);
    check("start_gap_ge2", min_gap >= 2, 1);

    // Frame 2: slow engine, window must stay frozen while start is held.
    eng_delay = 20;
    wb = wr_a.size();
    pulse_go();
    wait_start(200, ok);
    check("f2_start_seen", ok, 1);
    snap_x = eng_x;
    snap_d = out_data;
    held = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!eng_start) break;
      held++;
      if (eng_x !== snap_x || out_data !== snap_d || out_wr_en) bad++;
    end
    check("f2_hold_stable", bad, 0);
    check("f2_hold_cycles", held, 20);
    check("f2_first_wr_en", out_wr_en, 1);
    check("f2_first_data", out_data, 63);
    wait_frame_done(3000, ok);
    check("f2_done_seen", ok, 1);
    @(negedge clk);
    verify_frame(wb, "f2");

    // Frame 3: reset during COMPUTE of window 5, then restart.
    eng_delay = 4;
    wb = wr_a.size();
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (wr_a.size() - wb >= 5 && eng_start) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("f3_win5_seen", ok, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mr_ctrl", {busy, frame_done, pix_rd_en, eng_start, out_wr_en}, 0);
    check("mr_addrs", {pix_addr, out_addr}, 0);
    check("mr_eng_x", eng_x, 0);
    check("mr_out_data", out_data, 0);
    check("mr_nwr", wr_a.size() - wb, 5);
    reset = 1'b0;
    @(negedge clk);
    check("mr_idle", busy, 0);
    wb = wr_a.size();
    pulse_go();
    wait_frame_done(2000, ok);
    check("f4_done_seen", ok, 1);
    @(negedge clk);
    verify_frame(wb, "f4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
